exec_muldiv_unit: RTL and testbench

Multi-cycle RV64M multiply/divide functional unit for the execute stage. It sits beside the single-cycle ALU and takes forwarded operands plus func3 from the execute-stage operand muxes. It runs an iterative or pipelined operation and returns a registered result with the destination register address. While an operation is in flight it raises a stall request to the hazard unit.

---
 rtl/exec_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_unit.sv
// RV64M execute-stage multiply/divide unit (multi-cycle, stall-driving).
// Optional *W ops are enabled by defining MULDIV_W_OPS_EN.
module exec_muldiv_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_valid,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_flush,
  input  logic                  i_stall_mem,
`ifdef MULDIV_W_OPS_EN
  input  logic                  i_word,
`endif
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  localparam int W       = DATA_WIDTH;
  localparam int CNT_MAX = (W > MUL_LATENCY) ? W : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  function automatic logic sgn_a(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd2) ||
           (f == 3'd4) || (f == 3'd6);
  endfunction

  function automatic logic sgn_b(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd4) ||
           (f == 3'd6);
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          r_q, r_d;
  logic [W-1:0]          res_q, res_d;
  logic [2:0]            f3_q, f3_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
`ifdef MULDIV_W_OPS_EN
  logic                  word_q, word_d;
`endif

  logic [W-1:0] in_a, in_b, in_min;
  logic [W-1:0] in_mag_a, in_mag_b, in_div_a;
  logic [W-1:0] sp_res;
  logic         in_sa, in_sb;
  logic         div_zero, div_ovf;

  // Condition the offered operands: width, sign, divider seed, special cases
  always_comb begin
    in_a   = i_src_1;
    in_b   = i_src_2;
    in_min = {1'b1, {(W-1){1'b0}}};
`ifdef MULDIV_W_OPS_EN
    if (i_word) begin
      in_a   = {{(W-32){sgn_a(i_func3) & i_src_1[31]}},
                i_src_1[31:0]};
      in_b   = {{(W-32){sgn_b(i_func3) & i_src_2[31]}},
                i_src_2[31:0]};
      in_min = {{(W-31){1'b1}}, 31'd0};
    end
`endif
    in_sa    = sgn_a(i_func3) & in_a[W-1];
    in_sb    = sgn_b(i_func3) & in_b[W-1];
    in_mag_a = in_sa ? -in_a : in_a;
    in_mag_b = in_sb ? -in_b : in_b;
    in_div_a = in_mag_a;
    div_zero = (in_b == '0);
    div_ovf  = sgn_a(i_func3) & sgn_b(i_func3) &
               (in_a == in_min) & (in_b == '1);
    if (div_zero)
      sp_res = i_func3[1] ? in_a : '1;
    else
      sp_res = i_func3[1] ? '0 : in_a;
`ifdef MULDIV_W_OPS_EN
    if (i_word) begin
      in_div_a = in_mag_a << (W - 32);
      sp_res   = {{(W-32){sp_res[31]}}, sp_res[31:0]};
    end
`endif
  end

  logic [W-1:0]   mx_a, mx_b, mul_res;
  logic [2:0]     mx_f3;
  logic [2*W-1:0] prod;

  // Shared multiplier: live operands in IDLE, latched ones otherwise
  always_comb begin
    mx_a    = (state_q == S_IDLE) ? in_a : a_q;
    mx_b    = (state_q == S_IDLE) ? in_b : b_q;
    mx_f3   = (state_q == S_IDLE) ? i_func3 : f3_q;
    prod    = {{W{sgn_a(mx_f3) & mx_a[W-1]}}, mx_a} *
              {{W{sgn_b(mx_f3) & mx_b[W-1]}}, mx_b};
    mul_res = (mx_f3 == 3'd0) ? prod[W-1:0]
                              : prod[2*W-1:W];
`ifdef MULDIV_W_OPS_EN
    if ((state_q == S_IDLE) ? i_word : word_q)
      mul_res = {{(W-32){prod[31]}}, prod[31:0]};
`endif
  end

  logic [W:0]   r_sh;
  logic         ge;
  logic [W-1:0] st_r, st_q, div_res;
  logic         last;

  // One restoring-divide step plus the sign fix-up of its outcome
  always_comb begin
    r_sh    = {r_q, a_q[W-1]};
    ge      = (r_sh >= {1'b0, b_q});
    st_r    = ge ? (r_sh[W-1:0] - b_q) : r_sh[W-1:0];
    st_q    = {a_q[W-2:0], ge};
    if (f3_q[1])
      div_res = sa_q ? -st_r : st_r;
    else
      div_res = (sa_q ^ sb_q) ? -st_q : st_q;
    last    = (cnt_q == CNT_W'(W - 1));
`ifdef MULDIV_W_OPS_EN
    if (word_q) begin
      div_res = {{(W-32){div_res[31]}}, div_res[31:0]};
      last    = (cnt_q == CNT_W'(31));
    end
`endif
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    res_d   = res_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
`ifdef MULDIV_W_OPS_EN
    word_d  = word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          f3_d  = i_func3;
          rd_d  = i_rd_addr;
          sa_d  = in_sa;
          sb_d  = in_sb;
          cnt_d = '0;
          r_d   = '0;
`ifdef MULDIV_W_OPS_EN
          word_d = i_word;
`endif
          if (!i_func3[2]) begin
            a_d = in_a;
            b_d = in_b;
            if (MUL_LATENCY == 1) begin
              state_d = S_DONE;
              res_d   = mul_res;
            end else begin
              state_d = S_MUL;
            end
          end else if (div_zero || div_ovf) begin
            state_d = S_DONE;
            res_d   = sp_res;
          end else begin
            a_d     = in_div_a;
            b_d     = in_mag_b;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_LATENCY - 2)) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
        a_d   = st_q;
        r_d   = st_r;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          res_d   = div_res;
        end
      end
      S_DONE: begin
        if (!i_stall_mem)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush)
      state_d = S_IDLE;
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`ifdef MULDIV_W_OPS_EN
      word_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`ifdef MULDIV_W_OPS_EN
      word_q  <= word_d;
`endif
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = (state_q == S_DONE);
  assign o_busy    = (state_q != S_IDLE) &
                     ~((state_q == S_DONE) & ~i_stall_mem);
  assign o_result  = res_q;
  assign o_rd_addr = rd_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Bench for exec_muldiv_unit: directed literals plus random ops
// checked every cycle against an arithmetic reference model.
module tb_exec_muldiv_unit;

  localparam int W  = 64;
  localparam int RA = 5;
  localparam int ML = 3;

  logic          clk;
  logic          i_arst;
  logic          i_valid;
  logic [2:0]    i_func3;
  logic [W-1:0]  i_src_1;
  logic [W-1:0]  i_src_2;
  logic [RA-1:0] i_rd_addr;
  logic          i_flush;
  logic          i_stall_mem;
  logic          i_word;
  logic          o_ready;
  logic          o_busy;
  logic          o_valid;
  logic [W-1:0]  o_result;
  logic [RA-1:0] o_rd_addr;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  exec_muldiv_unit #(
    .DATA_WIDTH (W),
    .REG_ADDR_W (RA),
    .MUL_LATENCY(ML)
  ) dut (
    .i_clk      (clk),
    .i_arst     (i_arst),
    .i_valid    (i_valid),
    .i_func3    (i_func3),
    .i_src_1    (i_src_1),
    .i_src_2    (i_src_2),
    .i_rd_addr  (i_rd_addr),
    .i_flush    (i_flush),
    .i_stall_mem(i_stall_mem),
`ifdef MULDIV_W_OPS_EN
    .i_word     (i_word),
`endif
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Architectural result of one RV64M op
  function automatic logic [63:0] ref_res(input logic [2:0] f,
      input logic [63:0] a, input logic [63:0] b, input logic w);
    logic signed [129:0] pa, pb, pp;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    bit s1, s2;
    s1 = (f == 3'd1) || (f == 3'd2);
    s2 = (f == 3'd1);
    if (!f[2]) begin
      if (w) return sx32(a[31:0] * b[31:0]);
      pa = s1 ? $signed({{66{a[63]}}, a}) : $signed({66'd0, a});
      pb = s2 ? $signed({{66{b[63]}}, b}) : $signed({66'd0, b});
      pp = pa * pb;
      return (f == 3'd0) ? pp[63:0] : pp[127:64];
    end
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) r32 = f[1] ? a32 : 32'hFFFF_FFFF;
      else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
        r32 = f[1] ? 32'd0 : a32;
      else if (!f[0])
        r32 = f[1] ? $signed(a32) % $signed(b32)
                   : $signed(a32) / $signed(b32);
      else
        r32 = f[1] ? a32 % b32 : a32 / b32;
      return sx32(r32);
    end
    if (b == 0) r = f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1)
      r = f[1] ? 64'd0 : a;
    else if (!f[0])
      r = f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    else
      r = f[1] ? a % b : a / b;
    return r;
  endfunction

  // Cycles from accept edge (counted as 1) to result
  function automatic int ref_lat(input logic [2:0] f,
      input logic [63:0] a, input logic [63:0] b, input logic w);
    logic [63:0] min_v;
    bit zero, ovf;
    if (!f[2]) return ML;
    min_v = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
    zero  = w ? (b[31:0] == 0) : (b == 0);
    ovf   = !f[0] &&
            (w ? (a[31:0] == min_v[31:0] && b[31:0] == 32'hFFFF_FFFF)
               : (a == min_v && b == '1));
    if (zero || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_rem  = 0;
  logic [63:0] exp_res = '0;
  logic [4:0]  exp_rd  = '0;

  // Transaction-level model of the unit, advanced on each edge
  always @(posedge clk) begin
    if (i_arst) begin
      m_busy = 0;
      m_done = 0;
    end else if (i_flush) begin
      m_busy = 0;
      m_done = 0;
    end else if (m_done) begin
      if (!i_stall_mem) m_done = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (i_valid) begin
      exp_res = ref_res(i_func3, i_src_1, i_src_2, i_word);
      exp_rd  = i_rd_addr;
      m_rem   = ref_lat(i_func3, i_src_1, i_src_2, i_word) - 1;
      if (m_rem == 0) m_done = 1;
      else m_busy = 1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 64'(o_ready), 64'(!m_busy && !m_done));
      chk("cyc_valid", 64'(o_valid), 64'(m_done));
      chk("cyc_busy", 64'(o_busy),
          64'(m_busy || (m_done && i_stall_mem)));
      if (m_done) begin
        chk("cyc_result", o_result, exp_res);
        chk("cyc_rd", 64'(o_rd_addr), 64'(exp_rd));
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic w);
    int n;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    i_valid   = 1'b1;
    i_func3   = f;
    i_src_1   = a;
    i_src_2   = b;
    i_rd_addr = rd;
    i_word    = w;
    @(posedge clk); #1;
    i_valid   = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic w,
                        input logic [63:0] lit, input int lat);
    int n;
    bit busy_ok;
    chk({nm, "_model"}, ref_res(f, a, b, w), lit);
    issue(f, a, b, rd, w);
    n = 1;
    busy_ok = 1;
    while (!o_valid && n < 200) begin
      if (!o_busy) busy_ok = 0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_res"}, o_result, lit);
    chk({nm, "_rd"}, 64'(o_rd_addr), 64'(rd));
    if (lat > 1) chk({nm, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return {$urandom, 32'hFFFF_FFFF};
      5: return 64'($urandom_range(0, 20));
      6: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    bit seen;
    i_arst      = 1'b1;
    i_valid     = 1'b0;
    i_func3     = 3'd0;
    i_src_1     = '0;
    i_src_2     = '0;
    i_rd_addr   = '0;
    i_flush     = 1'b0;
    i_stall_mem = 1'b0;
    i_word      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_arst = 1'b0;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_rd", 64'(o_rd_addr), 64'd0);
    chk_en = 1;

    run_op("mul", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0,
           64'hFFFF_FFFF_FFFF_FFEB, 3);
    run_op("mulhu", 3'd3, '1, '1, 5'd6, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("mulhsu", 3'd2, '1, 64'd2, 5'd7, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 3);
    run_op("mulh", 3'd1, 64'h8000_0000_0000_0000, 64'd2, 5'd8, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 3);
    run_op("div", 3'd4, -64'd7, 64'd2, 5'd9, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem", 3'd6, -64'd7, 64'd2, 5'd10, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu", 3'd5, 64'd100, 64'd7, 5'd11, 1'b0, 64'd14, 65);
    run_op("remu", 3'd7, 64'd100, 64'd7, 5'd12, 1'b0, 64'd2, 65);
    run_op("divu0", 3'd5, 64'd5, 64'd0, 5'd13, 1'b0, '1, 1);
    run_op("rem0", 3'd6, 64'd5, 64'd0, 5'd14, 1'b0, 64'd5, 1);
    run_op("divovf", 3'd4, 64'h8000_0000_0000_0000, '1, 5'd15, 1'b0,
           64'h8000_0000_0000_0000, 1);
    run_op("removf", 3'd6, 64'h8000_0000_0000_0000, '1, 5'd16, 1'b0,
           64'd0, 1);
`ifdef MULDIV_W_OPS_EN
    run_op("divw", 3'd4, 64'h1_8000_0000, 64'd2, 5'd17, 1'b1,
           64'hFFFF_FFFF_C000_0000, 33);
    run_op("mulw", 3'd3, 64'h1_0000_0003, 64'h7FFF_FFFF, 5'd18, 1'b1,
           64'h0000_0000_7FFF_FFFD, 3);
`endif

    issue(3'd5, 64'd1000, 64'd3, 5'd20, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_ready", 64'(o_ready), 64'd1);
    chk("flush_valid", 64'(o_valid), 64'd0);
    seen = 0;
    repeat (70) begin
      if (o_valid) seen = 1;
      @(posedge clk); #1;
    end
    chk("flush_noresult", 64'(seen), 64'd0);
    run_op("postflush", 3'd0, 64'd6, 64'd7, 5'd21, 1'b0, 64'd42, 3);

    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("vflush_ready", 64'(o_ready), 64'd1);
    chk("vflush_busy", 64'(o_busy), 64'd0);

    i_stall_mem = 1'b1;
    issue(3'd0, 64'd3, 64'd5, 5'd22, 1'b0);
    n = 1;
    while (!o_valid && n < 200) begin @(posedge clk); #1; n++; end
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_result", o_result, 64'd15);
    end
    i_stall_mem = 1'b0;
    @(posedge clk); #1;
    chk("stall_exit", 64'(o_valid), 64'd0);

    issue(3'd4, 64'd12345, 64'd17, 5'd23, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    i_arst = 1'b1;
    @(posedge clk); #1;
    i_arst = 1'b0;
    chk("mrst_ready", 64'(o_ready), 64'd1);
    chk("mrst_busy", 64'(o_busy), 64'd0);
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_result", o_result, 64'd0);
    chk("mrst_rd", 64'(o_rd_addr), 64'd0);

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      i_valid     = 1'($urandom_range(0, 1));
      i_func3     = 3'($urandom);
      i_src_1     = rnd64();
      i_src_2     = rnd64();
      i_rd_addr   = 5'($urandom);
      i_flush     = ($urandom_range(0, 199) == 0);
      i_stall_mem = ($urandom_range(0, 2) == 0);
`ifdef MULDIV_W_OPS_EN
      i_word      = 1'($urandom_range(0, 1));
`endif
    end
    @(posedge clk); #1;
    i_valid     = 1'b0;
    i_flush     = 1'b0;
    i_stall_mem = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
